// File: rtl/if_prefetch_unit_pkg.sv
// Shared constants for the instruction-fetch prefetch unit.
// The fetch entry struct depends on XLEN, so it is declared in the top module.
// It holds the same {pc, instr} layout that the FIFO stores.
package if_prefetch_unit_pkg;

  // Byte distance between consecutive instructions (RV32/RV64 without C extension).
  localparam int unsigned INSTR_ALIGN = 4;
  localparam int unsigned ILEN        = 32;

endpackage

// File: rtl/if_prefetch_unit_fifo.sv
// Circular prefetch buffer holding fetched {pc, instr} entries.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i, data_i  write data_i at the tail
//   pop_i           advance the head (caller guarantees non-empty)
//   flush_i         drop all entries; overrides push/pop
//   head_o          entry at the head (undefined content when empty)
//   count_o         number of valid entries, 0..Depth
module if_prefetch_unit_fifo #(
  parameter int unsigned Depth = 4,
  parameter type T = logic [31:0],
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  T                data_i,
  output T                head_o,
  output logic [CntW-1:0] count_o
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PtrW:0] wr_q, wr_d, rd_q, rd_d;
  T              mem_q [Depth];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: entries are only observed while count_o > 0.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q[PtrW-1:0]] <= data_i;
  end

  assign head_o  = mem_q[rd_q[PtrW-1:0]];
  assign count_o = CntW'(wr_q - rd_q);

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: issues in-order IM requests, buffers responses
// and hands {instr, PC, PC+4} to decode with a valid/ready handshake.
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   IM_req_valid/ready, IM_address  fetch request channel
//   IM_rsp_valid, IM_out            in-order fetch responses (latency >= 1)
//   redirect_valid, redirect_pc     flush and restart fetch at redirect_pc
//   ID_valid/ready, ID_instr/PC/PC4 buffer head towards decode (zero when empty)
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter int unsigned    XLEN     = 32,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            IM_req_valid,
  input  logic            IM_req_ready,
  output logic [XLEN-1:0] IM_address,
  input  logic            IM_rsp_valid,
  input  logic [ILEN-1:0] IM_out,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ID_valid,
  input  logic            ID_ready,
  output logic [ILEN-1:0] ID_instr,
  output logic [XLEN-1:0] ID_PC,
  output logic [XLEN-1:0] ID_PC4
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d, discard_q, discard_d;
  logic [CntW-1:0] count;
  logic [CntW:0]   in_use;
  logic            req_fire, push, pop, dropping;
  logic [XLEN-1:0] redirect_pc_aligned;
  fetch_entry_t    push_entry, head;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_pc_aligned  = {redirect_pc[XLEN-1:2], 2'b00};

  // Credits cover both buffered and in-flight fetches; a pop in the same
  // cycle is deliberately not credited to keep the path short.
  assign in_use       = {1'b0, count} + {1'b0, outstanding_q};
  assign IM_req_valid = rst && !redirect_valid && (in_use < (CntW + 1)'(DEPTH));
  assign req_fire     = IM_req_valid && IM_req_ready;
  assign dropping     = (discard_q != '0);
  assign push         = IM_rsp_valid && !dropping && !redirect_valid;
  assign pop          = ID_valid && ID_ready;
  assign push_entry   = '{pc: rsp_pc_q, instr: IM_out};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(IM_rsp_valid);
    discard_d     = discard_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc_aligned;
      rsp_pc_d   = redirect_pc_aligned;
      // Everything still in flight after this cycle belongs to the old path.
      discard_d  = outstanding_q - CntW'(IM_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(INSTR_ALIGN);
      if (push)     rsp_pc_d   = rsp_pc_q + XLEN'(INSTR_ALIGN);
      if (IM_rsp_valid && dropping) discard_d = discard_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  if_prefetch_unit_fifo #(
    .Depth (DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_i  (push_entry),
    .head_o  (head),
    .count_o (count)
  );

  assign IM_address = fetch_pc_q;
  assign ID_valid   = (count != '0);
  assign ID_instr   = ID_valid ? head.instr : '0;
  assign ID_PC      = ID_valid ? head.pc : '0;
  assign ID_PC4     = ID_valid ? head.pc + XLEN'(INSTR_ALIGN) : '0;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst) begin
      assert (outstanding_q <= CntW'(DEPTH));
      assert (in_use <= (CntW + 1)'(DEPTH));
      assert (discard_q <= outstanding_q);
    end
  end
`endif

endmodule
